tt_um_xor_descrambler: RTL and testbench

- Receive end of the team's XOR-scrambled serial link. The transmit side sends each line bit as data XOR key; this block recovers the data.
- Hunts for an unscrambled sync word, then descrambles PAYLOAD_BYTES bytes with a frame-synchronous 7-bit LFSR keystream.
- Presents each byte on uo_out with a one-cycle valid strobe.
- Standard Tiny Tapeout user-module wrapper; serial pins arrive asynchronously on ui_in.

---
 rtl/tt_descr_pkg.sv | 22 ++
 rtl/descrambler_lfsr7.sv | 32 +++
 rtl/tt_um_xor_descrambler.sv | 162 ++++++++++++++++
 tb/tb_tt_um_xor_descrambler.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tt_descr_pkg.sv
// Shared types and constants for the XOR descrambler: FSM states, default
// sync word / LFSR seed, and the keystream LFSR tap positions.
package tt_descr_pkg;

    typedef enum logic [1:0] {
        HUNT = 2'd0,
        DATA = 2'd1,
        PAR  = 2'd2
    } descr_state_t;

    localparam logic [7:0] DEF_SYNC_WORD = 8'hA5;
    localparam logic [6:0] DEF_LFSR_SEED = 7'h7F;

    localparam int LFSR_TAP_HI = 6;
    localparam int LFSR_TAP_LO = 5;

    // One keystream step: shift left, feedback is the XOR of the two taps.
    function automatic logic [6:0] lfsr7_next(input logic [6:0] state);
        return {state[5:0], state[LFSR_TAP_HI] ^ state[LFSR_TAP_LO]};
    endfunction

endpackage

// File: rtl/descrambler_lfsr7.sv
// 7-bit Fibonacci LFSR producing the descrambler keystream; load wins over step.
module descrambler_lfsr7
    import tt_descr_pkg::*;
#(
    parameter logic [6:0] RESET_VAL = DEF_LFSR_SEED
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic       step,
    input  logic [6:0] seed,
    output logic       key
);

    logic [6:0] state_r;

    // Keystream state register with load-over-step priority.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= RESET_VAL;
        end else if (load) begin
            state_r <= seed;
        end else if (step) begin
            state_r <= lfsr7_next(state_r);
        end else begin
            state_r <= state_r;
        end
    end

    assign key = state_r[LFSR_TAP_HI];

endmodule

// File: rtl/tt_um_xor_descrambler.sv
// Receive-side XOR descrambler: hunts for the sync word, then descrambles a frame.
// Optional trailing even-parity check is built when PARITY_CHECK_EN is defined.
module tt_um_xor_descrambler
    import tt_descr_pkg::*;
#(
    parameter logic [7:0] SYNC_WORD     = DEF_SYNC_WORD,
    parameter int         PAYLOAD_BYTES = 4,
    parameter logic [6:0] LFSR_SEED     = DEF_LFSR_SEED
) (
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe,
    input  logic       ena,
    input  logic       clk,
    input  logic       rst_n
);

    localparam logic [7:0] LAST_BYTE = 8'(PAYLOAD_BYTES - 1);

    logic [1:0]   sync1_r, sync2_r;
    logic         prev_r;
    logic         rise_s, bit_s, key_s, data_bit_s;
    logic         lfsr_load_s, lfsr_step_s;
    logic [7:0]   new_window_s, new_byte_s;
    descr_state_t state_r;
    logic [7:0]   window_r;
    logic [6:0]   byte_sr_r;
    logic [2:0]   bit_cnt_r;
    logic [7:0]   byte_cnt_r;
    logic [7:0]   uo_r;
    logic         byte_valid_r, in_frame_r, frame_done_r;
    logic         parity_err_s;
    wire          unused_s = &{1'b0, ena, uio_in, ui_in[7:2]};

    // Two-flop synchronizer on rx_bit/rx_strobe plus strobe history for edge detect.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_r <= 2'b00;
            sync2_r <= 2'b00;
            prev_r  <= 1'b0;
        end else begin
            sync1_r <= ui_in[1:0];
            sync2_r <= sync1_r;
            prev_r  <= sync2_r[1];
        end
    end

    assign rise_s       = sync2_r[1] & ~prev_r;
    assign bit_s        = sync2_r[0];
    assign data_bit_s   = bit_s ^ key_s;
    assign new_window_s = {window_r[6:0], bit_s};
    assign new_byte_s   = {byte_sr_r, data_bit_s};
    assign lfsr_load_s  = rise_s && (state_r == HUNT) && (new_window_s == SYNC_WORD);
    assign lfsr_step_s  = rise_s && (state_r == DATA);

    descrambler_lfsr7 #(.RESET_VAL(LFSR_SEED)) u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (lfsr_load_s),
        .step  (lfsr_step_s),
        .seed  (LFSR_SEED),
        .key   (key_s)
    );

`ifdef PARITY_CHECK_EN
    logic run_xor_r;
    logic parity_err_r;

    // Running XOR of descrambled payload bits and the sticky parity verdict.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_xor_r    <= 1'b0;
            parity_err_r <= 1'b0;
        end else if (rise_s && state_r == HUNT) begin
            run_xor_r    <= 1'b0;
            parity_err_r <= parity_err_r;
        end else if (rise_s && state_r == DATA) begin
            run_xor_r    <= run_xor_r ^ data_bit_s;
            parity_err_r <= parity_err_r;
        end else if (rise_s && state_r == PAR) begin
            run_xor_r    <= run_xor_r;
            parity_err_r <= (bit_s != run_xor_r);
        end else begin
            run_xor_r    <= run_xor_r;
            parity_err_r <= parity_err_r;
        end
    end

    assign parity_err_s = parity_err_r;
`else
    assign parity_err_s = 1'b0;
`endif

    // Frame FSM: sync hunt, payload descrambling and registered status strobes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= HUNT;
            window_r     <= 8'h00;
            byte_sr_r    <= 7'h00;
            bit_cnt_r    <= 3'd0;
            byte_cnt_r   <= 8'd0;
            uo_r         <= 8'h00;
            byte_valid_r <= 1'b0;
            in_frame_r   <= 1'b0;
            frame_done_r <= 1'b0;
        end else begin
            byte_valid_r <= 1'b0;
            frame_done_r <= 1'b0;
            if (rise_s) begin
                case (state_r)
                    HUNT: begin
                        window_r <= new_window_s;
                        if (new_window_s == SYNC_WORD) begin
                            state_r    <= DATA;
                            bit_cnt_r  <= 3'd0;
                            byte_cnt_r <= 8'd0;
                            in_frame_r <= 1'b1;
                        end
                    end
                    DATA: begin
                        byte_sr_r <= new_byte_s[6:0];
                        bit_cnt_r <= bit_cnt_r + 3'd1;
                        if (bit_cnt_r == 3'd7) begin
                            uo_r         <= new_byte_s;
                            byte_valid_r <= 1'b1;
                            byte_cnt_r   <= byte_cnt_r + 8'd1;
                            if (byte_cnt_r == LAST_BYTE) begin
`ifdef PARITY_CHECK_EN
                                state_r <= PAR;
`else
                                state_r      <= HUNT;
                                frame_done_r <= 1'b1;
                                in_frame_r   <= 1'b0;
                                window_r     <= 8'h00;
`endif
                            end
                        end
                    end
`ifdef PARITY_CHECK_EN
                    PAR: begin
                        state_r      <= HUNT;
                        frame_done_r <= 1'b1;
                        in_frame_r   <= 1'b0;
                        window_r     <= 8'h00;
                    end
`endif
                    default: begin
                        state_r  <= HUNT;
                        window_r <= 8'h00;
                    end
                endcase
            end
        end
    end

    assign uo_out  = uo_r;
    assign uio_out = {4'b0000, parity_err_s, frame_done_r, in_frame_r, byte_valid_r};
    assign uio_oe  = 8'h0F;

endmodule

// File: tb/tb_tt_um_xor_descrambler.sv
// Directed self-checking bench for tt_um_xor_descrambler (keystream FE 04 18 51).
module tb_tt_um_xor_descrambler;

    logic [7:0] ui_in;
    logic [7:0] uo_out;
    logic [7:0] uio_in;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;
    logic       ena;
    logic       clk;
    logic       rst_n;

    int n_vec = 0;
    int n_err = 0;
    int bv_cnt = 0;
    int fd_cnt = 0;
    logic [7:0] got[$];

    tt_um_xor_descrambler dut (
        .ui_in   (ui_in),
        .uo_out  (uo_out),
        .uio_in  (uio_in),
        .uio_out (uio_out),
        .uio_oe  (uio_oe),
        .ena     (ena),
        .clk     (clk),
        .rst_n   (rst_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Counts output strobes and captures each completed byte.
    always @(negedge clk) begin
        if (rst_n && uio_out[0]) begin
            bv_cnt <= bv_cnt + 1;
            got.push_back(uo_out);
        end
        if (rst_n && uio_out[2]) fd_cnt <= fd_cnt + 1;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b, input int hi);
        ui_in[0] = b;
        ui_in[1] = 1'b1;
        repeat (hi) tick();
        ui_in[1] = 1'b0;
        repeat (3) tick();
    endtask

    task automatic send_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) send_bit(b[i], 3);
    endtask

    // Ends a frame: parity bit in the parity build, then checks frame_done/in_frame.
    task automatic finish_frame(input logic [31:0] data, input logic flip, input int fd0);
`ifdef PARITY_CHECK_EN
        send_bit((^data) ^ flip, 3);
        n_vec++;
        if (uio_out[3] !== flip) begin
            n_err++;
            $display("FAIL parity_err: got %b want %b", uio_out[3], flip);
        end
`else
        n_vec++;
        if (uio_out[3] !== 1'b0) begin
            n_err++;
            $display("FAIL parity_tied: got %b want 0", uio_out[3]);
        end
`endif
        n_vec++;
        if (fd_cnt - fd0 !== 1 || uio_out[1] !== 1'b0) begin
            n_err++;
            $display("FAIL frame_done: got %0d pulses in_frame=%b want 1 pulse in_frame=0",
                     fd_cnt - fd0, uio_out[1]);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        ui_in = 8'h02;
        repeat (4) tick();
        n_vec++;
        if (uo_out !== 8'h00 || uio_out !== 8'h00 || uio_oe !== 8'h0F) begin
            n_err++;
            $display("FAIL reset: got uo=%h uio=%h oe=%h want 00 00 0f", uo_out, uio_out, uio_oe);
        end
        ui_in = 8'h00;
        tick();
        rst_n = 1'b1;
        repeat (3) tick();
    endtask

    task automatic test_first_byte;
        int bv0, fd0;
        logic [7:0] sync;
        logic [7:0] exp [4];
        sync = 8'hA5;
        exp  = '{8'h00, 8'h11, 8'h22, 8'h33};
        bv0 = bv_cnt;
        fd0 = fd_cnt;
        got.delete();
        for (int i = 7; i >= 1; i--) send_bit(sync[i], 3);
        n_vec++;
        if (uio_out[1] !== 1'b0) begin
            n_err++;
            $display("FAIL in_frame_early: got %b want 0", uio_out[1]);
        end
        send_bit(sync[0], 3);
        n_vec++;
        if (uio_out[1] !== 1'b1) begin
            n_err++;
            $display("FAIL in_frame_lock: got %b want 1", uio_out[1]);
        end
        send_byte(8'hFE);
        n_vec++;
        if (bv_cnt - bv0 !== 1 || uo_out !== 8'h00) begin
            n_err++;
            $display("FAIL first_byte: got %0d pulses uo=%h want 1 pulse uo=00", bv_cnt - bv0, uo_out);
        end
        send_byte(8'h15);
        send_byte(8'h3A);
        send_byte(8'h62);
        finish_frame(32'h00112233, 1'b0, fd0);
        n_vec++;
        if (got.size() !== 4) begin
            n_err++;
            $display("FAIL frame1_count: got %0d bytes want 4", got.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                n_vec++;
                if (got[i] !== exp[i]) begin
                    n_err++;
                    $display("FAIL frame1_byte%0d: got %h want %h", i, got[i], exp[i]);
                end
            end
        end
        repeat (10) tick();
        n_vec++;
        if (uo_out !== 8'h33) begin
            n_err++;
            $display("FAIL uo_hold: got %h want 33", uo_out);
        end
    endtask

    task automatic test_back_to_back;
        int fd0;
        logic [7:0] exp [8];
        exp = '{8'hFE, 8'h00, 8'h00, 8'h00, 8'hEC, 8'hA1, 8'hA5, 8'h00};
        fd0 = fd_cnt;
        got.delete();
        send_byte(8'h3C);
        for (int i = 3; i >= 0; i--) send_bit(i[0] == 1'b0 ? 1'b1 : 1'b0, 3);
        n_vec++;
        if (uio_out[1] !== 1'b0) begin
            n_err++;
            $display("FAIL noise_no_lock: got %b want 0", uio_out[1]);
        end
        send_byte(8'hA5);
        send_byte(8'h00);
        send_byte(8'h04);
        send_byte(8'h18);
        send_byte(8'h51);
        finish_frame(32'hFE000000, 1'b0, fd0);
        fd0 = fd_cnt;
        send_byte(8'hA5);
        n_vec++;
        if (uio_out[1] !== 1'b1) begin
            n_err++;
            $display("FAIL relock: got in_frame=%b want 1", uio_out[1]);
        end
        send_byte(8'h12);
        send_byte(8'hA5);
        n_vec++;
        if (uio_out[1] !== 1'b1 || fd_cnt !== fd0) begin
            n_err++;
            $display("FAIL sync_in_payload: got in_frame=%b fd=%0d want 1 %0d", uio_out[1], fd_cnt, fd0);
        end
        send_byte(8'hBD);
        send_byte(8'h51);
        finish_frame(32'hECA1A500, 1'b0, fd0);
        n_vec++;
        if (got.size() !== 8) begin
            n_err++;
            $display("FAIL b2b_count: got %0d bytes want 8", got.size());
        end else begin
            for (int i = 0; i < 8; i++) begin
                n_vec++;
                if (got[i] !== exp[i]) begin
                    n_err++;
                    $display("FAIL b2b_byte%0d: got %h want %h", i, got[i], exp[i]);
                end
            end
        end
    endtask

    task automatic test_timing;
        int bv0, fd0;
        fd0 = fd_cnt;
        send_byte(8'hA5);
        bv0 = bv_cnt;
        send_bit(1'b1, 10);
        for (int i = 0; i < 6; i++) send_bit(1'b1, 3);
        ui_in[0] = 1'b0;
        ui_in[1] = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        n_vec++;
        if (uio_out[0] !== 1'b0) begin
            n_err++;
            $display("FAIL latency_early: got valid=%b at edge 2 want 0", uio_out[0]);
        end
        @(posedge clk);
        #1;
        n_vec++;
        if (uio_out[0] !== 1'b1 || uo_out !== 8'h00) begin
            n_err++;
            $display("FAIL latency_edge3: got valid=%b uo=%h want 1 00", uio_out[0], uo_out);
        end
        ui_in[1] = 1'b0;
        repeat (3) tick();
        n_vec++;
        if (bv_cnt - bv0 !== 1) begin
            n_err++;
            $display("FAIL long_strobe: got %0d pulses want 1", bv_cnt - bv0);
        end
        send_byte(8'h04);
        send_byte(8'h18);
        send_byte(8'h51);
        finish_frame(32'h00000000, 1'b0, fd0);
    endtask

    task automatic test_reset_mid;
        send_byte(8'hA5);
        send_bit(1'b1, 3);
        send_bit(1'b0, 3);
        #2;
        rst_n = 1'b0;
        #1;
        n_vec++;
        if (uio_out[1] !== 1'b0 || uo_out !== 8'h00) begin
            n_err++;
            $display("FAIL reset_mid: got in_frame=%b uo=%h want 0 00", uio_out[1], uo_out);
        end
        tick();
        rst_n = 1'b1;
        tick();
        send_byte(8'hFE);
        n_vec++;
        if (uio_out[1] !== 1'b0) begin
            n_err++;
            $display("FAIL reset_hunt: got in_frame=%b want 0", uio_out[1]);
        end
    endtask

`ifdef PARITY_CHECK_EN
    task automatic test_parity;
        int fd0;
        for (int f = 0; f < 3; f++) begin
            fd0 = fd_cnt;
            send_byte(8'hA5);
            send_byte(8'hFE);
            send_byte(8'h04);
            send_byte(8'h18);
            send_byte(8'h50);
            finish_frame(32'h00000001, (f == 1) ? 1'b1 : 1'b0, fd0);
            if (f == 1) begin
                repeat (20) tick();
                n_vec++;
                if (uio_out[3] !== 1'b1) begin
                    n_err++;
                    $display("FAIL parity_hold: got %b want 1", uio_out[3]);
                end
            end
        end
    endtask
`endif

    initial begin
        uio_in = 8'h00;
        ena    = 1'b1;
        test_reset();
        test_first_byte();
        test_back_to_back();
        test_timing();
        test_reset_mid();
`ifdef PARITY_CHECK_EN
        test_parity();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
